// File: rtl/c8_step_counter.sv
// rtl/c8_step_counter.sv - 8-bit step counter operand stage with command/result handshake
//
// Purpose: owns the counter value consumed by the downstream load/increment
// datapath. Accepts LOAD / CLEAR / STEP / RUN commands over a valid/ready
// handshake and presents each finished command as a held count + wrap flag.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  block idle and able to accept a command
//   cmd_op     00 LOAD, 01 CLEAR, 10 STEP, 11 RUN
//   cmd_data   LOAD value or RUN repeat count
//   out_valid  result available (held until out_ready)
//   out_ready  downstream accepts result
//   out_count  counter register, visible in every state
//   out_wrap   an increment of the last command wrapped all-ones -> 0
//   busy       block not idle
module c8_step_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_count,
  output logic             out_wrap,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_EMIT = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_RUN   = 2'b11;

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] remaining;
  logic             wrap;

  // Handshake flags come from state alone so neither side sees a
  // combinational path through the block.
  assign cmd_ready = (state == S_IDLE);
  assign out_valid = (state == S_EMIT);
  assign busy      = (state != S_IDLE);
  assign out_count = count;
  assign out_wrap  = wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      count     <= '0;
      remaining <= '0;
      wrap      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            wrap <= 1'b0;
            case (cmd_op)
              OP_LOAD: begin
                count <= cmd_data;
                state <= S_EMIT;
              end
              OP_CLEAR: begin
                count <= '0;
                state <= S_EMIT;
              end
              OP_STEP: begin
                count <= count + 1'b1;
                wrap  <= (count == '1);
                state <= S_EMIT;
              end
              OP_RUN: begin
                remaining <= cmd_data;
                // A zero-length run reports the unchanged count at once.
                state     <= (cmd_data == '0) ? S_EMIT : S_RUN;
              end
              default: state <= S_IDLE;
            endcase
          end
        end

        S_RUN: begin
          count     <= count + 1'b1;
          remaining <= remaining - 1'b1;
          // Sticky: any wrap during the run, including on its last edge.
          if (count == '1) begin
            wrap <= 1'b1;
          end
          if (remaining == WIDTH'(1)) begin
            state <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
